// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, colour-field slices and fill-engine state encoding.
// Used by the fill engine and by the VGA scan-out.
package fb_pkg;

  localparam int FB_W     = 80;
  localparam int FB_H     = 60;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int AW       = 13;

  localparam int R_HI = 7;
  localparam int R_LO = 5;
  localparam int G_HI = 4;
  localparam int G_LO = 2;
  localparam int B_HI = 1;
  localparam int B_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FIN  = 2'd2
  } fill_state_e;

  // y*80 as y*64 + y*16, so no multiplier is needed.
  function automatic logic [AW-1:0] row_base_of(input logic [5:0] y);
    logic [AW-1:0] yz;
    yz = {{(AW-6){1'b0}}, y};
    return (yz << 6) + (yz << 4);
  endfunction

endpackage

// File: rtl/fb_fill_if.sv
// Command and write-port bundle between a fill client, the fill engine and the framebuffer.
interface fb_fill_if;
  import fb_pkg::*;

  logic          start;
  logic [6:0]    x0;
  logic [5:0]    y0;
  logic [6:0]    w;
  logic [5:0]    h;
  logic [7:0]    color;
  logic          wr_wait;
  logic          busy;
  logic          done;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;

  modport master (
    input  start, x0, y0, w, h, color, wr_wait,
    output busy, done, we, addr, wdata
  );

  modport slave (
    output start, x0, y0, w, h, color, wr_wait,
    input  busy, done, we, addr, wdata
  );

endinterface

// File: rtl/fb_clip.sv
// Combinational clip of a requested rectangle to the framebuffer bounds.
module fb_clip
  import fb_pkg::*;
(
  input  logic [6:0] x0_i,
  input  logic [5:0] y0_i,
  input  logic [6:0] w_i,
  input  logic [5:0] h_i,
  output logic [6:0] x_start_o,
  output logic [6:0] x_end_o,
  output logic [5:0] y_start_o,
  output logic [5:0] y_end_o,
  output logic       empty_o
);

  logic [7:0] x_sum_s;
  logic [6:0] y_sum_s;

  // Sums are one bit wider than the operands so a far origin plus a large size cannot wrap.
  always_comb begin
    x_sum_s   = {1'b0, x0_i} + {1'b0, w_i};
    y_sum_s   = {1'b0, y0_i} + {1'b0, h_i};
    x_start_o = x0_i;
    y_start_o = y0_i;
    if (x_sum_s > 8'(FB_W)) begin
      x_end_o = 7'(FB_W);
    end else begin
      x_end_o = x_sum_s[6:0];
    end
    if (y_sum_s > 7'(FB_H)) begin
      y_end_o = 6'(FB_H);
    end else begin
      y_end_o = y_sum_s[5:0];
    end
    empty_o = (w_i == 7'd0) || (h_i == 6'd0) ||
              (x0_i >= 7'(FB_W)) || (y0_i >= 6'(FB_H));
  end

endmodule

// File: rtl/fb_fill.sv
// Rectangle-fill engine: latches one clipped command and emits one framebuffer write per
// accepted cycle, row-major, on a registered write port that an arbiter may stall.
module fb_fill
  import fb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  fb_fill_if.master  fill_io
);

  fill_state_e   state_q, state_d;
  logic [6:0]    col_q, col_d;
  logic [5:0]    row_q, row_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [6:0]    x_start_q, x_start_d;
  logic [6:0]    x_end_q, x_end_d;
  logic [5:0]    y_end_q, y_end_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [6:0]    clip_x_start_s;
  logic [6:0]    clip_x_end_s;
  logic [5:0]    clip_y_start_s;
  logic [5:0]    clip_y_end_s;
  logic          clip_empty_s;
  logic          last_col_s;
  logic          last_row_s;
  logic [AW-1:0] next_row_base_s;

  fb_clip u_clip (
    .x0_i      (fill_io.x0),
    .y0_i      (fill_io.y0),
    .w_i       (fill_io.w),
    .h_i       (fill_io.h),
    .x_start_o (clip_x_start_s),
    .x_end_o   (clip_x_end_s),
    .y_start_o (clip_y_start_s),
    .y_end_o   (clip_y_end_s),
    .empty_o   (clip_empty_s)
  );

  // Next-state, counter and write-port logic; a stalled write leaves everything held.
  always_comb begin
    state_d         = state_q;
    col_d           = col_q;
    row_d           = row_q;
    row_base_d      = row_base_q;
    x_start_d       = x_start_q;
    x_end_d         = x_end_q;
    y_end_d         = y_end_q;
    we_d            = we_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    last_col_s      = (col_q == (x_end_q - 7'd1));
    last_row_s      = (row_q == (y_end_q - 6'd1));
    next_row_base_s = row_base_q + AW'(FB_W);

    case (state_q)
      ST_IDLE: begin
        we_d   = 1'b0;
        busy_d = 1'b0;
        if (fill_io.start) begin
          x_start_d  = clip_x_start_s;
          x_end_d    = clip_x_end_s;
          y_end_d    = clip_y_end_s;
          col_d      = clip_x_start_s;
          row_d      = clip_y_start_s;
          row_base_d = row_base_of(clip_y_start_s);
          wdata_d    = fill_io.color;
          busy_d     = 1'b1;
          if (clip_empty_s) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_FILL;
            we_d    = 1'b1;
            addr_d  = row_base_of(clip_y_start_s) + {{(AW-7){1'b0}}, clip_x_start_s};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FILL: begin
        if (fill_io.wr_wait) begin
          state_d = ST_FILL;
        end else if (last_col_s && last_row_s) begin
          // DONE is raised on the edge that returns to IDLE so a new START is taken while it is high.
          state_d = ST_IDLE;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (last_col_s) begin
          col_d      = x_start_q;
          row_d      = row_q + 6'd1;
          row_base_d = next_row_base_s;
          addr_d     = next_row_base_s + {{(AW-7){1'b0}}, x_start_q};
        end else begin
          col_d  = col_q + 7'd1;
          addr_d = row_base_q + {{(AW-7){1'b0}}, col_q + 7'd1};
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      col_q      <= 7'd0;
      row_q      <= 6'd0;
      row_base_q <= '0;
      x_start_q  <= 7'd0;
      x_end_q    <= 7'd0;
      y_end_q    <= 6'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      x_start_q  <= x_start_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign fill_io.we    = we_q;
  assign fill_io.addr  = addr_q;
  assign fill_io.wdata = wdata_q;
  assign fill_io.busy  = busy_q;
  assign fill_io.done  = done_q;

endmodule

// File: tb/tb_fb_fill.sv
// Directed bench for fb_fill: a vector table of fill commands with hand-computed write counts,
// addresses and DONE latency, plus hand-written reset-mid-fill and stall sequences.
module tb_fb_fill;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_fill_if bus ();

  fb_fill u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .fill_io (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0]  x0;
    logic [5:0]  y0;
    logic [6:0]  w;
    logic [5:0]  h;
    logic [7:0]  color;
    logic [31:0] wait_mask;
    int          inj_k;
    int          exp_n;
    int          exp_first;
    int          exp_last;
    int          exp_done_k;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issues a command at the current negedge and follows it until DONE or a cycle budget.
  task automatic run_cmd(input vec_t v, input string name);
    int exp_q[$];
    int xe, ye, k, nwr, first, last, done_k, hold_addr;
    bit hold;
    xe = int'(v.x0) + int'(v.w);
    if (xe > 80) xe = 80;
    ye = int'(v.y0) + int'(v.h);
    if (ye > 60) ye = 60;
    for (int r = int'(v.y0); r < ye; r++)
      for (int c = int'(v.x0); c < xe; c++)
        exp_q.push_back(r * 80 + c);

    bus.x0 = v.x0; bus.y0 = v.y0; bus.w = v.w; bus.h = v.h; bus.color = v.color;
    bus.start = 1'b1;
    bus.wr_wait = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, "_busy_start"}, int'(bus.busy), 1);

    k = 0; nwr = 0; done_k = -1; first = -1; last = -1; hold = 1'b0; hold_addr = 0;
    while (k < 200) begin
      if (hold) begin
        chk({name, "_hold_we"}, int'(bus.we), 1);
        chk({name, "_hold_addr"}, int'(bus.addr), hold_addr);
        hold = 1'b0;
      end
      if (bus.done) begin
        done_k = k;
        break;
      end
      if (k == v.inj_k) begin
        bus.start = 1'b1; bus.color = ~v.color;
        bus.x0 = 7'd0; bus.y0 = 6'd0; bus.w = 7'd1; bus.h = 6'd1;
      end else begin
        bus.start = 1'b0;
      end
      bus.wr_wait = (k < 32) ? v.wait_mask[k] : 1'b0;
      if (bus.we) begin
        chk({name, "_addr_range"}, int'(bus.addr < AW'(FB_DEPTH)), 1);
        if (bus.wr_wait) begin
          hold = 1'b1;
          hold_addr = int'(bus.addr);
        end else begin
          chk({name, "_wdata"}, int'(bus.wdata), int'(v.color));
          if (nwr < exp_q.size())
            chk($sformatf("%s_addr%0d", name, nwr), int'(bus.addr), exp_q[nwr]);
          if (first < 0) first = int'(bus.addr);
          last = int'(bus.addr);
          nwr++;
        end
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    bus.wr_wait = 1'b0;
    chk({name, "_done_k"}, done_k, v.exp_done_k);
    chk({name, "_nwrites"}, nwr, v.exp_n);
    chk({name, "_model_n"}, nwr, exp_q.size());
    chk({name, "_first"}, first, v.exp_first);
    chk({name, "_last"}, last, v.exp_last);
    chk({name, "_busy_at_done"}, int'(bus.busy), 0);
    chk({name, "_we_at_done"}, int'(bus.we), 0);
  endtask

  initial begin
    vecs[0]  = '{7'd5,   6'd2,  7'd1,   6'd1,  8'hE0, 32'h0, -1, 1, 165,  165,  1};
    vecs[1]  = '{7'd78,  6'd58, 7'd3,   6'd2,  8'h1C, 32'h0, -1, 4, 4718, 4799, 4};
    vecs[2]  = '{7'd10,  6'd10, 7'd0,   6'd5,  8'hFF, 32'h0, -1, 0, -1,   -1,   1};
    vecs[3]  = '{7'd80,  6'd0,  7'd5,   6'd5,  8'h12, 32'h0, -1, 0, -1,   -1,   1};
    vecs[4]  = '{7'd10,  6'd63, 7'd4,   6'd10, 8'h34, 32'h0, -1, 0, -1,   -1,   1};
    vecs[5]  = '{7'd0,   6'd0,  7'd3,   6'd2,  8'h03, 32'h0, -1, 6, 0,    82,   6};
    vecs[6]  = '{7'd75,  6'd0,  7'd127, 6'd1,  8'hC3, 32'h0, -1, 5, 75,   79,   5};
    vecs[7]  = '{7'd0,   6'd59, 7'd2,   6'd63, 8'h4A, 32'h0, -1, 2, 4720, 4721, 2};
    vecs[8]  = '{7'd0,   6'd0,  7'd4,   6'd1,  8'h55, 32'h6, -1, 4, 0,    3,    6};
    vecs[9]  = '{7'd10,  6'd20, 7'd8,   6'd1,  8'hAA, 32'h0, 3,  8, 1610, 1617, 8};
    vecs[10] = '{7'd127, 6'd63, 7'd127, 6'd63, 8'h01, 32'h0, -1, 0, -1,   -1,   1};

    rst = 1'b1;
    bus.start = 1'b0; bus.wr_wait = 1'b0;
    bus.x0 = 7'd0; bus.y0 = 6'd0; bus.w = 7'd0; bus.h = 6'd0; bus.color = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_we", int'(bus.we), 0);
    chk("rst_addr", int'(bus.addr), 0);
    chk("rst_wdata", int'(bus.wdata), 0);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive calls start in the DONE cycle, so back-to-back acceptance is exercised too.
    for (int i = 0; i < 11; i++)
      run_cmd(vecs[i], $sformatf("v%0d", i));

    @(negedge clk);
    bus.x0 = 7'd0; bus.y0 = 6'd0; bus.w = 7'd10; bus.h = 6'd10; bus.color = 8'h3C;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_fill_we", int'(bus.we), 1);
    chk("mid_fill_addr", int'(bus.addr), 5);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we", int'(bus.we), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_addr", int'(bus.addr), 0);
    chk("midrst_wdata", int'(bus.wdata), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_done%0d", i), int'(bus.done), 0);
      chk($sformatf("postrst_we%0d", i), int'(bus.we), 0);
    end
    run_cmd(vecs[0], "after_rst");
    run_cmd(vecs[1], "after_rst_corner");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
